// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register pending-write counters, CSR busy flag and
// one outstanding control transfer, combined into the DE stall/issue decision.
module hazard_scoreboard #(
  parameter int REGWORDS  = 32,
  parameter int REGNOBITS = 5,
  parameter int CNTBITS   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 de_valid,
  input  logic [REGNOBITS-1:0] de_rs1,
  input  logic                 de_rs1_used,
  input  logic [REGNOBITS-1:0] de_rs2,
  input  logic                 de_rs2_used,
  input  logic [REGNOBITS-1:0] de_rd,
  input  logic                 de_wr_reg,
  input  logic                 de_csr_rd,
  input  logic                 de_csr_wr,
  input  logic                 de_is_ctrl,
  input  logic                 wb_wr_reg,
  input  logic [REGNOBITS-1:0] wb_wregno,
  input  logic                 wb_wr_csr,
  input  logic                 agex_ctrl_resolved,
  output logic                 stall_DE,
  output logic                 issue_DE,
  output logic [REGWORDS-1:0]  busy_bits,
  output logic                 csr_busy,
  output logic                 ctrl_pending,
  output logic                 err_underflow
);

  localparam logic [CNTBITS-1:0]   CNT_ZERO = {CNTBITS{1'b0}};
  localparam logic [CNTBITS-1:0]   CNT_ONE  = {{(CNTBITS-1){1'b0}}, 1'b1};
  localparam logic [CNTBITS-1:0]   CNT_MAX  = {CNTBITS{1'b1}};
  localparam logic [REGNOBITS-1:0] REG_X0   = {REGNOBITS{1'b0}};

  logic [CNTBITS-1:0]  cnt [REGWORDS];
  logic [CNTBITS-1:0]  eff [REGWORDS];
  logic [REGWORDS-1:0] inc;
  logic [REGWORDS-1:0] dec;
  logic                raw;
  logic                sat;
  logic                csr_haz;
  logic                under_reg;
  logic                under_csr;

  // Effective counts see this cycle's WB release, since the regfile writes on negedge
  always_comb begin
    dec = {REGWORDS{1'b0}};
    for (int r = 0; r < REGWORDS; r++) begin
      eff[r] = cnt[r];
      if (r != 0 && wb_wr_reg && wb_wregno == REGNOBITS'(r) && cnt[r] != CNT_ZERO) begin
        dec[r] = 1'b1;
        eff[r] = cnt[r] - CNT_ONE;
      end else begin
        dec[r] = 1'b0;
      end
    end
  end

  // Counter increments for the destination of an issuing instruction
  always_comb begin
    inc = {REGWORDS{1'b0}};
    for (int r = 1; r < REGWORDS; r++) begin
      if (issue_DE && de_wr_reg && de_rd == REGNOBITS'(r)) begin
        inc[r] = 1'b1;
      end else begin
        inc[r] = 1'b0;
      end
    end
  end

  assign raw = (de_rs1_used && de_rs1 != REG_X0 && eff[de_rs1] != CNT_ZERO) ||
               (de_rs2_used && de_rs2 != REG_X0 && eff[de_rs2] != CNT_ZERO);
  assign sat       = de_wr_reg && de_rd != REG_X0 && eff[de_rd] == CNT_MAX;
  assign csr_haz   = (de_csr_rd || de_csr_wr) && csr_busy && !wb_wr_csr;
  assign stall_DE  = de_valid && (raw || sat || csr_haz || ctrl_pending);
  assign issue_DE  = de_valid && !stall_DE;
  assign under_reg = wb_wr_reg && wb_wregno != REG_X0 && cnt[wb_wregno] == CNT_ZERO;
  assign under_csr = wb_wr_csr && !csr_busy;

  // Busy vector mirrors nonzero counters
  always_comb begin
    busy_bits = {REGWORDS{1'b0}};
    for (int r = 0; r < REGWORDS; r++) begin
      busy_bits[r] = (cnt[r] != CNT_ZERO);
    end
  end

  // Pending-write counters; x0 is never touched after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < REGWORDS; r++) begin
        cnt[r] <= CNT_ZERO;
      end
    end else begin
      for (int r = 0; r < REGWORDS; r++) begin
        if (inc[r] && !dec[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec[r] && !inc[r]) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end else begin
          cnt[r] <= cnt[r];
        end
      end
    end
  end

  // CSR, control-transfer and sticky underflow flags; a new set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) begin
      csr_busy      <= 1'b0;
      ctrl_pending  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (issue_DE && de_csr_wr) begin
        csr_busy <= 1'b1;
      end else if (wb_wr_csr) begin
        csr_busy <= 1'b0;
      end else begin
        csr_busy <= csr_busy;
      end
      if (issue_DE && de_is_ctrl) begin
        ctrl_pending <= 1'b1;
      end else if (agex_ctrl_resolved) begin
        ctrl_pending <= 1'b0;
      end else begin
        ctrl_pending <= ctrl_pending;
      end
      err_underflow <= err_underflow || under_reg || under_csr;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against an array-based reference model.
module tb_hazard_scoreboard;
  localparam int REGWORDS  = 32;
  localparam int REGNOBITS = 5;
  localparam int CNTBITS   = 2;
  localparam int CMAX      = (1 << CNTBITS) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 de_valid, de_rs1_used, de_rs2_used, de_wr_reg;
  logic                 de_csr_rd, de_csr_wr, de_is_ctrl;
  logic [REGNOBITS-1:0] de_rs1, de_rs2, de_rd, wb_wregno;
  logic                 wb_wr_reg, wb_wr_csr, agex_ctrl_resolved;
  logic                 stall_DE, issue_DE, csr_busy, ctrl_pending, err_underflow;
  logic [REGWORDS-1:0]  busy_bits;

  hazard_scoreboard #(.REGWORDS(REGWORDS), .REGNOBITS(REGNOBITS), .CNTBITS(CNTBITS)) dut (
    .clk(clk), .reset(reset), .de_valid(de_valid),
    .de_rs1(de_rs1), .de_rs1_used(de_rs1_used), .de_rs2(de_rs2), .de_rs2_used(de_rs2_used),
    .de_rd(de_rd), .de_wr_reg(de_wr_reg), .de_csr_rd(de_csr_rd), .de_csr_wr(de_csr_wr),
    .de_is_ctrl(de_is_ctrl), .wb_wr_reg(wb_wr_reg), .wb_wregno(wb_wregno),
    .wb_wr_csr(wb_wr_csr), .agex_ctrl_resolved(agex_ctrl_resolved),
    .stall_DE(stall_DE), .issue_DE(issue_DE), .busy_bits(busy_bits),
    .csr_busy(csr_busy), .ctrl_pending(ctrl_pending), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: in-flight write count per register and three flags
  int cnt_m [REGWORDS];
  bit csr_m, ctrl_m, err_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_m(input int r);
    if (r == 0) return 0;
    if (wb_wr_reg && int'(wb_wregno) == r && cnt_m[r] > 0) return cnt_m[r] - 1;
    return cnt_m[r];
  endfunction

  function automatic bit exp_stall();
    bit raw, sat, csr_h;
    raw   = (de_rs1_used && eff_m(int'(de_rs1)) != 0) || (de_rs2_used && eff_m(int'(de_rs2)) != 0);
    sat   = de_wr_reg && de_rd != 0 && eff_m(int'(de_rd)) == CMAX;
    csr_h = (de_csr_rd || de_csr_wr) && csr_m && !wb_wr_csr;
    return de_valid && (raw || sat || csr_h || ctrl_m);
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] b = 32'h0;
    for (int r = 0; r < REGWORDS; r++) if (cnt_m[r] != 0) b[r] = 1'b1;
    return b;
  endfunction

  task automatic compare_model();
    bit st;
    if (!reset) begin
      st = exp_stall();
      check("model_stall", stall_DE, st);
      check("model_issue", issue_DE, de_valid && !st);
      check("model_busy", busy_bits, exp_busy());
      check("model_csr_busy", csr_busy, csr_m);
      check("model_ctrl", ctrl_pending, ctrl_m);
      check("model_err", err_underflow, err_m);
    end
  endtask

  task automatic update_model();
    bit iss;
    if (reset) begin
      for (int r = 0; r < REGWORDS; r++) cnt_m[r] = 0;
      csr_m = 0; ctrl_m = 0; err_m = 0;
    end else begin
      iss = de_valid && !exp_stall();
      if (wb_wr_reg && wb_wregno != 0) begin
        if (cnt_m[wb_wregno] == 0) err_m = 1;
        else cnt_m[wb_wregno]--;
      end
      if (iss && de_wr_reg && de_rd != 0) cnt_m[de_rd]++;
      if (wb_wr_csr && !csr_m) err_m = 1;
      if (iss && de_csr_wr) csr_m = 1;
      else if (wb_wr_csr) csr_m = 0;
      if (iss && de_is_ctrl) ctrl_m = 1;
      else if (agex_ctrl_resolved) ctrl_m = 0;
    end
  endtask

  // One clock: compare settled outputs, advance model at the edge, return at negedge
  task automatic cyc();
    #1 compare_model();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle();
    de_valid = 0; de_rs1 = '0; de_rs1_used = 0; de_rs2 = '0; de_rs2_used = 0;
    de_rd = '0; de_wr_reg = 0; de_csr_rd = 0; de_csr_wr = 0; de_is_ctrl = 0;
    wb_wr_reg = 0; wb_wregno = '0; wb_wr_csr = 0; agex_ctrl_resolved = 0;
  endtask

  task automatic instr(input int rs1, input bit u1, input int rs2, input bit u2, input int rd,
                       input bit wr, input bit crd, input bit cwr, input bit ctl);
    de_valid = 1; de_rs1 = REGNOBITS'(rs1); de_rs1_used = u1; de_rs2 = REGNOBITS'(rs2);
    de_rs2_used = u2; de_rd = REGNOBITS'(rd); de_wr_reg = wr; de_csr_rd = crd;
    de_csr_wr = cwr; de_is_ctrl = ctl;
  endtask

  task automatic wb_reg(input int r);
    wb_wr_reg = 1; wb_wregno = REGNOBITS'(r);
  endtask

  task automatic check_all_zero(input string tag);
    #1;
    check({tag, "_busy"}, busy_bits, 32'h0);
    check({tag, "_csr"}, csr_busy, 1'b0);
    check({tag, "_ctrl"}, ctrl_pending, 1'b0);
    check({tag, "_err"}, err_underflow, 1'b0);
    check({tag, "_stall"}, stall_DE, 1'b0);
    check({tag, "_issue"}, issue_DE, 1'b0);
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    cyc(); cyc();
    reset = 0;
    check_all_zero("reset");

    // Back-to-back RAW on x5
    instr(0, 1, 0, 0, 5, 1, 0, 0, 0); #1 check("raw_addi_issue", issue_DE, 1'b1); cyc();
    idle(); #1 check("raw_busy_x5", busy_bits, 32'h20);
    instr(5, 1, 0, 1, 6, 1, 0, 0, 0); #1 check("raw_stall0", stall_DE, 1'b1); cyc();
    #1 check("raw_stall1", stall_DE, 1'b1); cyc();
    wb_reg(5); #1 check("raw_wb_stall", stall_DE, 1'b0); check("raw_wb_issue", issue_DE, 1'b1); cyc();
    idle(); #1 check("raw_busy_after", busy_bits, 32'h40);
    wb_reg(6); cyc(); idle(); #1 check("raw_busy_clear", busy_bits, 32'h0);

    // x0 is never tracked
    instr(0, 1, 0, 0, 0, 1, 0, 0, 0); #1 check("x0_issue", issue_DE, 1'b1); cyc();
    idle(); #1 check("x0_busy", busy_bits, 32'h0);
    instr(0, 1, 0, 1, 1, 1, 0, 0, 0); #1 check("x0_nostall", stall_DE, 1'b0); cyc();
    idle(); #1 check("x0_busy_x1", busy_bits, 32'h2);
    wb_reg(1); cyc(); idle();

    // Counter saturation on x7
    repeat (3) begin instr(0, 0, 0, 0, 7, 1, 0, 0, 0); cyc(); end
    idle(); #1 check("sat_busy", busy_bits, 32'h80);
    instr(0, 0, 0, 0, 7, 1, 0, 0, 0); #1 check("sat_stall", stall_DE, 1'b1); cyc();
    wb_reg(7); #1 check("sat_wb_stall", stall_DE, 1'b0); check("sat_wb_issue", issue_DE, 1'b1); cyc();
    wb_wr_reg = 0; #1 check("sat_still_full", stall_DE, 1'b1); cyc();
    idle(); repeat (3) begin wb_reg(7); cyc(); end
    idle(); #1 check("sat_drained", busy_bits, 32'h0);

    // Control transfer
    instr(1, 1, 2, 1, 0, 0, 0, 0, 1); cyc();
    idle(); #1 check("ctl_pending", ctrl_pending, 1'b1);
    instr(0, 0, 0, 0, 3, 1, 0, 0, 0); #1 check("ctl_stall", stall_DE, 1'b1); cyc();
    agex_ctrl_resolved = 1; #1 check("ctl_resolve_stall", stall_DE, 1'b1); cyc();
    agex_ctrl_resolved = 0; #1 check("ctl_cleared", ctrl_pending, 1'b0);
    check("ctl_issue", issue_DE, 1'b1); cyc();
    idle(); wb_reg(3); cyc(); idle();

    // CSR interlock
    instr(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();
    idle(); #1 check("csr_busy_set", csr_busy, 1'b1);
    instr(0, 0, 0, 0, 4, 1, 1, 0, 0); #1 check("csr_stall", stall_DE, 1'b1); cyc();
    wb_wr_csr = 1; #1 check("csr_wb_stall", stall_DE, 1'b0); check("csr_wb_issue", issue_DE, 1'b1); cyc();
    idle(); #1 check("csr_busy_clr", csr_busy, 1'b0);
    wb_reg(4); cyc(); idle();
    instr(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();
    wb_wr_csr = 1; #1 check("csr_set_wins_issue", issue_DE, 1'b1); cyc();
    idle(); #1 check("csr_set_wins", csr_busy, 1'b1);
    wb_wr_csr = 1; cyc(); idle(); #1 check("csr_final_clr", csr_busy, 1'b0);

    // Randomized legal traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      int r;
      de_valid    = ($urandom_range(3) != 0);
      de_rs1      = REGNOBITS'($urandom_range(7));
      de_rs1_used = ($urandom_range(1) == 1);
      de_rs2      = REGNOBITS'($urandom_range(7));
      de_rs2_used = ($urandom_range(1) == 1);
      de_rd       = REGNOBITS'($urandom_range(7));
      de_wr_reg   = ($urandom_range(9) < 7);
      de_csr_rd   = ($urandom_range(9) == 0);
      de_csr_wr   = ($urandom_range(9) == 0);
      de_is_ctrl  = ($urandom_range(9) == 0);
      r = int'($urandom_range(1, 7));
      wb_wregno   = REGNOBITS'(r);
      wb_wr_reg   = (cnt_m[r] > 0) && ($urandom_range(1) == 1);
      wb_wr_csr   = csr_m && ($urandom_range(2) == 0);
      agex_ctrl_resolved = ctrl_m && ($urandom_range(2) == 0);
      cyc();
    end
    idle();
    for (int k = 0; k < 40; k++) begin
      idle();
      for (int r = 1; r < 8; r++) if (cnt_m[r] > 0 && wb_wr_reg == 0) wb_reg(r);
      wb_wr_csr = csr_m;
      agex_ctrl_resolved = ctrl_m;
      cyc();
    end
    idle();
    #1 check("rand_no_err", err_underflow, 1'b0);
    check("rand_drained", busy_bits, 32'h0);

    // Underflow is sticky
    wb_reg(9); cyc(); idle();
    #1 check("uf_set", err_underflow, 1'b1);
    cyc(); cyc(); cyc();
    #1 check("uf_sticky", err_underflow, 1'b1);

    // Reset mid-operation discards pending state
    reset = 1; cyc(); reset = 0;
    #1 check("rst_err_clr", err_underflow, 1'b0);
    instr(0, 0, 0, 0, 5, 1, 0, 0, 0); cyc(); cyc();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 1); cyc();
    idle(); #1 check("pre_rst_ctrl", ctrl_pending, 1'b1); check("pre_rst_busy", busy_bits, 32'h20);
    reset = 1; cyc(); reset = 0;
    check_all_zero("midrst");
    instr(5, 1, 0, 0, 6, 1, 0, 0, 0); #1 check("midrst_no_raw", stall_DE, 1'b0); cyc();
    idle(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
